// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path (scanner, decoder and their benches).
package seven_segment_pkg;

    localparam int DIGIT_W        = 4;
    localparam int SEG_W          = 7;
    localparam int DEFAULT_DIGITS = 4;

    typedef logic [DIGIT_W-1:0]                digit_t;
    typedef logic [DEFAULT_DIGITS*DIGIT_W-1:0] digit_vec_t;

    function automatic logic is_zero(input digit_t d);
        return d == '0;
    endfunction

endpackage

// File: rtl/seven_segment_scanner_scan_timer.sv
// Slot/digit counters for the display scanner: slot position, digit index, frame end and blank window.
module scan_timer
    import seven_segment_pkg::*;
#(
    parameter  int DIGITS       = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 2,
    localparam int CNT_W        = $clog2(REFRESH_DIV),
    localparam int IDX_W        = $clog2(DIGITS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_frame_done,
    output logic             o_in_blank
);

    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             w_slot_end;
    logic             w_last_idx;

    assign w_slot_end = (r_cnt == CNT_W'(REFRESH_DIV - 1));
    assign w_last_idx = (r_idx == IDX_W'(DIGITS - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_idx        = r_idx;
    assign o_frame_done = w_slot_end && w_last_idx;
    // Anodes stay dark for the first few cycles of every slot to avoid ghosting.
    assign o_in_blank   = (r_cnt < CNT_W'(BLANK_CYCLES));

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver with frame-synchronous value update and leading-zero suppression.
module seven_segment_scanner
    import seven_segment_pkg::*;
#(
    parameter  int DIGITS       = 4,
    parameter  int REFRESH_DIV  = 50000,
    parameter  int BLANK_CYCLES = 2,
    localparam int IDX_W        = $clog2(DIGITS),
    localparam int VAL_W        = DIGITS * DIGIT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [VAL_W-1:0]   i_value,
    input  logic               i_load,
    input  logic               i_lzs_en,
    input  logic [DIGITS-1:0]  i_blank,
    output logic [DIGIT_W-1:0] o_digit_code,
    output logic [DIGITS-1:0]  o_anode_n,
    output logic [IDX_W-1:0]   o_digit_idx,
    output logic               o_frame_done
);

    logic [VAL_W-1:0]  r_pending;
    logic              r_pend_valid;
    logic [VAL_W-1:0]  r_active;

    logic [IDX_W-1:0]  w_idx;
    logic              w_frame_done;
    logic              w_in_blank;
    logic [DIGITS-1:0] w_zero_from;
    logic              w_suppressed;

    scan_timer #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .o_idx        (w_idx),
        .o_frame_done (w_frame_done),
        .o_in_blank   (w_in_blank)
    );

    // A load in the boundary cycle itself goes straight to the display, skipping the pending buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_active     <= '0;
        end else if (w_frame_done) begin
            if (i_load) begin
                r_active <= i_value;
            end else if (r_pend_valid) begin
                r_active <= r_pending;
            end
            r_pend_valid <= 1'b0;
        end else if (i_load) begin
            r_pending    <= i_value;
            r_pend_valid <= 1'b1;
        end
    end

    // w_zero_from[i] is set when digits i..DIGITS-1 of the shown value are all zero.
    always_comb begin
        logic acc;
        acc         = 1'b1;
        w_zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc            = acc && is_zero(r_active[i*DIGIT_W +: DIGIT_W]);
            w_zero_from[i] = acc;
        end
    end

    assign w_suppressed = i_lzs_en && (w_idx != '0) && w_zero_from[w_idx];

    always_comb begin
        o_digit_code = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                o_digit_code = r_active[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    always_comb begin
        o_anode_n = '1;
        if (!w_in_blank && !i_blank[w_idx] && !w_suppressed) begin
            o_anode_n[w_idx] = 1'b0;
        end
    end

    assign o_digit_idx  = w_idx;
    assign o_frame_done = w_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_seven_segment_scanner;

    localparam int DIGITS = 4;
    localparam int RD     = 8;
    localparam int BC     = 2;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int VAL_W  = DIGITS * 4;
    localparam int OUT_W  = IDX_W + 4 + DIGITS + 1;
    localparam int FRAME  = DIGITS * RD;

    logic              clk;
    logic              rst;
    logic [VAL_W-1:0]  value;
    logic              load;
    logic              lzs_en;
    logic [DIGITS-1:0] blank;
    logic [3:0]        digit_code;
    logic [DIGITS-1:0] anode_n;
    logic [IDX_W-1:0]  digit_idx;
    logic              frame_done;

    int nChecks = 0;
    int nPass   = 0;

    int               mT;
    logic [VAL_W-1:0] mActive;
    logic [VAL_W-1:0] mPending;
    logic             mPendValid;

    seven_segment_scanner #(
        .DIGITS       (DIGITS),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_value      (value),
        .i_load       (load),
        .i_lzs_en     (lzs_en),
        .i_blank      (blank),
        .o_digit_code (digit_code),
        .o_anode_n    (anode_n),
        .o_digit_idx  (digit_idx),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {digit_idx, digit_code, anode_n, frame_done} derived from the cycle position in the frame.
    function automatic logic [OUT_W-1:0] modelOut();
        int idx;
        int sc;
        logic [3:0] code;
        logic [DIGITS-1:0] an;
        logic fd;
        logic sup;
        idx  = (mT / RD) % DIGITS;
        sc   = mT % RD;
        code = 4'((mActive >> (4 * idx)) & 'hF);
        fd   = (sc == RD - 1) && (idx == DIGITS - 1);
        sup  = lzs_en && (idx > 0) && ((mActive >> (4 * idx)) == 0);
        an   = '1;
        if (sc >= BC && !blank[idx] && !sup) an = ~(DIGITS'(1) << idx);
        return {IDX_W'(idx), code, an, fd};
    endfunction

    function automatic logic [OUT_W-1:0] observed();
        return {digit_idx, digit_code, anode_n, frame_done};
    endfunction

    // Advance one clock: model consumes the inputs held during the cycle, then return to the negedge.
    task automatic adv();
        logic boundary;
        @(posedge clk);
        boundary = (mT % RD == RD - 1) && ((mT / RD) % DIGITS == DIGITS - 1);
        if (rst) begin
            mT = 0; mActive = '0; mPending = '0; mPendValid = 1'b0;
        end else begin
            if (boundary) begin
                if (load) mActive = value;
                else if (mPendValid) mActive = mPending;
                mPendValid = 1'b0;
            end else if (load) begin
                mPending   = value;
                mPendValid = 1'b1;
            end
            mT = (mT + 1) % FRAME;
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1; load = 1'b0; value = '0;
        adv();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b1; value = 16'hFFFF; lzs_en = 1'b0; blank = '0;
        adv();
        adv();
        rst = 1'b0; load = 1'b0;
        #1;
        nChecks++;
        if ({digit_idx, digit_code, anode_n, frame_done} !== {2'd0, 4'h0, 4'b1111, 1'b0})
            $display("[TB] FAIL reset_state: got %h expected %h", observed(), {2'd0, 4'h0, 4'b1111, 1'b0});
        else nPass++;
    endtask

    task automatic test_idle_scan();
        int pulses;
        pulses = 0;
        doReset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            #1;
            if (frame_done) pulses++;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL idle_scan c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            adv();
        end
        nChecks++;
        if (pulses !== 2) $display("[TB] FAIL idle_frame_pulses: got %0d expected 2", pulses);
        else nPass++;
    endtask

    task automatic test_load_mid_frame();
        doReset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            load  = (c == 5);
            value = (c == 5) ? 16'h1234 : 16'h0000;
            #1;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL load_mid c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            if (c == 31 || c == 32 || c == 40 || c == 56) begin
                nChecks++;
                if (digit_code !== ((c == 31) ? 4'h0 : (c == 32) ? 4'h4 : (c == 40) ? 4'h3 : 4'h1))
                    $display("[TB] FAIL load_mid_code c=%0d: got %h", c, digit_code);
                else nPass++;
            end
            adv();
        end
        load = 1'b0;
    endtask

    task automatic test_boundary_load();
        doReset();
        for (int c = 0; c < FRAME + 4; c++) begin
            load  = (c == 31);
            value = 16'hABCD;
            #1;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL boundary_load c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            if (c == 32) begin
                nChecks++;
                if (digit_code !== 4'hD) $display("[TB] FAIL boundary_bypass: got %h expected d", digit_code);
                else nPass++;
            end
            adv();
        end
        load = 1'b0;
    endtask

    task automatic test_back_to_back();
        doReset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            load  = (c == 3) || (c == 20);
            value = (c == 3) ? 16'h1111 : 16'h2222;
            #1;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL back_to_back c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            if (c >= 32 && (c % RD) == 4) begin
                nChecks++;
                if (digit_code !== 4'h2) $display("[TB] FAIL last_load_wins c=%0d: got %h expected 2", c, digit_code);
                else nPass++;
            end
            adv();
        end
        load = 1'b0;
    endtask

    task automatic test_lzs();
        logic [VAL_W-1:0] pats [2];
        pats[0] = 16'h0050;
        pats[1] = 16'h0000;
        lzs_en = 1'b1;
        for (int p = 0; p < 2; p++) begin
            doReset();
            for (int c = 0; c < 2 * FRAME; c++) begin
                load  = (c == 0);
                value = pats[p];
                #1;
                nChecks++;
                if (observed() !== modelOut())
                    $display("[TB] FAIL lzs p=%0d c=%0d: got %h expected %h", p, c, observed(), modelOut());
                else nPass++;
                if (c >= 32 && (c % RD) == 3) begin
                    nChecks++;
                    if (anode_n !== ((p == 0) ? ((c < 48) ? ~(4'b1 << ((c - 32) / RD)) : 4'b1111)
                                              : ((c < 40) ? 4'b1110 : 4'b1111)))
                        $display("[TB] FAIL lzs_anode p=%0d c=%0d: got %b", p, c, anode_n);
                    else nPass++;
                end
                adv();
            end
        end
        lzs_en = 1'b0; load = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        doReset();
        for (int c = 0; c < 19; c++) begin
            load  = (c == 2);
            value = 16'h9876;
            rst   = (c == 18);
            if (c == 18) begin load = 1'b1; value = 16'h5555; end
            #1;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL rst_mid c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            adv();
        end
        rst = 1'b0; load = 1'b0;
        #1;
        nChecks++;
        if ({digit_idx, digit_code, anode_n} !== {2'd0, 4'h0, 4'b1111})
            $display("[TB] FAIL rst_mid_restart: got %h expected 0_0_f", {digit_idx, digit_code, anode_n});
        else nPass++;
        for (int c = 0; c < 2 * FRAME; c++) begin
            #1;
            nChecks++;
            if (observed() !== modelOut() || digit_code !== 4'h0)
                $display("[TB] FAIL rst_mid_pending_lost c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            adv();
        end
    endtask

    task automatic test_random();
        doReset();
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom_range(0, 99) == 0);
            load   = ($urandom_range(0, 9) == 0);
            value  = VAL_W'($urandom);
            if ($urandom_range(0, 3) == 0) value[VAL_W-1 -: 8] = '0;
            lzs_en = $urandom_range(0, 1) == 1;
            blank  = ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '0;
            #1;
            nChecks++;
            if (observed() !== modelOut())
                $display("[TB] FAIL random c=%0d: got %h expected %h", c, observed(), modelOut());
            else nPass++;
            adv();
        end
        rst = 1'b0; load = 1'b0; blank = '0; lzs_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; value = '0; lzs_en = 1'b0; blank = '0;
        mT = 0; mActive = '0; mPending = '0; mPendValid = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_scan();
        test_load_mid_frame();
        test_boundary_load();
        test_back_to_back();
        test_lzs();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

- Time-multiplexed driver for a common-anode multi-digit 7-segment display.
- Holds a packed hexadecimal value and steps through the digits one at a time.
- Each cycle it presents the current 4-bit digit code to the downstream `binaryto7segment` decoder and drives the matching active-low anode.
- New values are double-buffered and only take effect at a frame boundary, so the display never shows a partially updated number.

## Interface
- `DIGITS`, 4, number of display digits; must be ≥ 2.
- `REFRESH_DIV`, 50000, clock cycles per digit slot; must be ≥ 2.
- `BLANK_CYCLES`, 2, cycles at the start of each slot with all anodes off (anti-ghosting); must be < `REFRESH_DIV`.
- Ports: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `value` in 4·DIGITS: packed digits; digit i is `value[4i+3:4i]`; digit 0 is the rightmost digit.
- `load` in 1: single-cycle strobe that captures `value` into the pending buffer.
- `lzs_en` in 1: leading-zero suppression enable.
- `blank` in DIGITS: per-digit force-off mask.
- `digit_code` out 4: nibble for the current slot; feeds `binaryto7segment.in`.
- `anode_n` out DIGITS: active-low digit enables.
- `digit_idx` out clog2(DIGITS): index of the current slot.
- `frame_done` out 1: one-cycle pulse on the last cycle of digit DIGITS-1.

## Operation
- State registers:
  - `cnt`: 0..REFRESH_DIV-1.
  - `idx`: 0..DIGITS-1.
  - `pending`: 4·DIGITS bits.
  - `pend_valid`: 1 bit.
  - `active`: 4·DIGITS bits.
- `cnt` increments every cycle. At REFRESH_DIV-1 it wraps to 0 and `idx` advances; `idx` wraps DIGITS-1 → 0.
- Frame boundary: the cycle where `cnt`=REFRESH_DIV-1 and `idx`=DIGITS-1. `frame_done`=1 in exactly that cycle.
- `load`=1 stores `value` in `pending` and sets `pend_valid`. A second load before the boundary overwrites `pending`; last one wins.
- At the frame boundary:
  - If `pend_valid`, then `active` ← `pending` and `pend_valid` is cleared.
  - If `load` is asserted in the boundary cycle itself, `active` ← `value` directly, bypassing `pending`, and `pend_valid` is cleared.
- `digit_code` = `active[4·idx+3 : 4·idx]`.
- Digit i is suppressed when `lzs_en`=1, i>0, and every digit from i up to DIGITS-1 of `active` is 0. Digit 0 is never suppressed by this rule.
- `anode_n[idx]`=0 only when all of the following hold; otherwise it is 1. All other bits of `anode_n` are always 1.
  - `cnt` ≥ BLANK_CYCLES
  - `blank[idx]`=0
  - digit `idx` is not suppressed
- `blank` and `lzs_en` act immediately and are not frame-buffered.
- All outputs are functions of registered state only; the only input-dependent terms are `blank` and `lzs_en` in the anode gating.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0, `active`=0, `pending`=0, `pend_valid`=0.
  - `digit_code`=0, `digit_idx`=0, `frame_done`=0.
  - `anode_n`=all ones, because `cnt`<BLANK_CYCLES.
- Digit slot length is REFRESH_DIV cycles. Frame length is DIGITS·REFRESH_DIV cycles.
- Load-to-display latency:
  - At most one frame plus one cycle.
  - Exactly 1 cycle when the load coincides with the boundary.
- Reset asserted mid-frame takes effect on the next edge. Any pending load is discarded, and scanning restarts at digit 0 with anodes off.
- `load` and `rst` in the same cycle: reset wins.

## Structure
- Shared package `seven_segment_pkg`:
  - `DIGIT_W`=4, `SEG_W`=7.
  - Typedef for the packed digit vector.
  - Shared with `binaryto7segment` and its bench.
- One natural sub-module: `scan_timer`, which holds the `cnt`/`idx` counters and generates `frame_done` and the blank window.
- The buffering and suppression logic stay in the top module.
- The decoder is instantiated by the parent, not inside this block.

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then idle 32 cycles:
  - `digit_idx` steps 0,1,2,3 every 8 cycles.
  - `frame_done` pulses at cycle 31 only.
  - `digit_code`=0 throughout.
  - `anode_n` for slot i is 1111 in slot cycles 0–1, then ~(1<<i).
- Load `value`=16'h1234 at cycle 5:
  - `digit_code` stays 0 until cycle 32.
  - Then slots show 4,3,2,1.
- Load 16'hABCD in the boundary cycle 31: slot 0 at cycle 32 shows D.
- Loads of 16'h1111 at cycle 3 and 16'h2222 at cycle 20: the frame starting at 32 shows all 2s.
- `lzs_en`=1 with 16'h0050:
  - Anodes for digits 2 and 3 stay 1.
  - Digits 1 and 0 light with codes 5 and 0.
  - With 16'h0000, only digit 0 lights.
- Assert `rst` for 1 cycle during slot 2 after loading 16'h9876:
  - Next cycle `digit_idx`=0, `digit_code`=0, `anode_n`=1111.
  - The pending value is lost.
